// File: rtl/lsu_subword_pkg.sv
// rtl/lsu_subword_pkg.sv - shared constants, state encoding and access checks for the sub-word LSU
package lsu_subword_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int WORD_LEN  = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // Store funct3 011 has no RV32I encoding, so it is rejected with the other illegal codes.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    if (we) illegal = f3[2] | (f3[1:0] == 2'b11);
    else    illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    misaligned = ((f3[1:0] == 2'b01) & lo[0]) | ((f3[1:0] == 2'b10) & (lo != 2'b00));
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_subword_if.sv
// rtl/lsu_subword_if.sv - CPU request/response and word-memory bus of the sub-word LSU
interface lsu_subword_if
  import lsu_subword_pkg::*;
#(
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = WORD_LEN
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/lsu_subword_lane.sv
// rtl/lsu_subword_lane.sv - byte/halfword lane extract+extend for loads and lane merge for stores
module lsu_subword_lane
  import lsu_subword_pkg::*;
(
  input  logic [WORD_LEN-1:0] rd_word,
  input  logic [1:0]          lo,
  input  logic [2:0]          f3,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] load_data,
  output logic [WORD_LEN-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lo)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lo[1] ? rd_word[31:16] : rd_word[15:0];

    // funct3[2] selects zero extension (LBU/LHU)
    case (f3[1:0])
      2'b00:   load_data = f3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = f3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase

    store_word = rd_word;
    case (f3[1:0])
      2'b00: begin
        case (lo)
          2'b00:   store_word[7:0]   = wdata[7:0];
          2'b01:   store_word[15:8]  = wdata[7:0];
          2'b10:   store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) store_word[31:16] = wdata[15:0];
        else       store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - RV32I load/store unit mapping byte/halfword accesses onto a word-only memory
module lsu_subword
  import lsu_subword_pkg::*;
#(
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = WORD_LEN
) (
  input  logic         clk,
  input  logic         rst,
  lsu_subword_if.slave bus
);

  state_t            state;
  logic              cap_we;
  logic [2:0]        cap_f3;
  logic [1:0]        cap_lo;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  lsu_subword_lane u_lane (
    .rd_word    (bus.mem_rdata),
    .lo         (cap_lo),
    .f3         (cap_f3),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cap_we         <= 1'b0;
      cap_f3         <= '0;
      cap_lo         <= '0;
      cap_wdata      <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            cap_we        <= bus.req_we;
            cap_f3        <= bus.req_funct3;
            cap_lo        <= bus.req_addr[1:0];
            cap_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) begin
              state         <= ST_WRITE;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state        <= ST_READ;
              bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_READ: begin
          // sub-word stores merge into the word just read; loads finish here
          if (cap_we) begin
            state         <= ST_WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= store_word;
          end else begin
            state          <= ST_RESP;
            bus.mem_addr   <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_data;
          end
        end
        ST_WRITE: begin
          state          <= ST_RESP;
          bus.mem_we     <= 1'b0;
          bus.mem_wdata  <= '0;
          bus.mem_addr   <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: begin
          state          <= ST_IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - self-checking bench for lsu_subword with a word memory and reference model
module tb_lsu_subword;
  import lsu_subword_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_subword_if bus ();

  lsu_subword dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] tbmem  [16];
  logic [31:0] refmem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign bus.mem_rdata = tbmem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_we) tbmem[pre_idx] <= pre_data;
    else if (bus.mem_we) tbmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
  end

  int n_checks = 0;
  int n_err = 0;

  logic        r_seen, r_err;
  logic [31:0] r_rdata, r_waddr, r_wdata;
  int          r_lat, r_pulses, r_wecyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    r_seen = 0; r_err = 0; r_rdata = 0; r_waddr = 0; r_wdata = 0;
    r_lat = 0; r_pulses = 0; r_wecyc = 0;
    for (int c = 1; c <= 10 && !r_seen; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        r_pulses++; r_wecyc = c; r_waddr = bus.mem_addr; r_wdata = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        r_seen = 1; r_lat = c; r_err = bus.resp_err; r_rdata = bus.resp_rdata;
      end
    end
    @(negedge clk);
    check("ready_after_resp", 32'(bus.req_ready), 32'd1);
    check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic verify(input string tag, input logic e_err, input logic [31:0] e_rd, input int e_lat,
                        input int e_pulses, input logic [31:0] e_waddr, input logic [31:0] e_wdata);
    check({tag, " resp_seen"}, 32'(r_seen), 32'd1);
    check({tag, " resp_err"}, 32'(r_err), 32'(e_err));
    check({tag, " resp_rdata"}, r_rdata, e_rd);
    check({tag, " latency"}, r_lat, e_lat);
    check({tag, " we_pulses"}, r_pulses, e_pulses);
    if (e_pulses > 0) begin
      check({tag, " we_cycle"}, r_wecyc, e_lat - 1);
      check({tag, " mem_addr"}, r_waddr, e_waddr);
      check({tag, " mem_wdata"}, r_wdata, e_wdata);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] old,
                                output logic err, output logic [31:0] rd, output int lat,
                                output logic [31:0] neww);
    int sz, off;
    logic [63:0] mask, val;
    off = int'(addr[1:0]);
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) err = f3[2] || (f3[1:0] == 2'b11);
    else    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((off % sz) != 0) err = 1'b1;
    mask = (64'd1 << (8 * sz)) - 64'd1;
    rd = 0; neww = old; lat = 1;
    if (!err && !we) begin
      val = ({32'd0, old} >> (8 * off)) & mask;
      if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
      rd = val[31:0];
      lat = 2;
    end else if (!err) begin
      mask = mask << (8 * off);
      neww = (old & ~mask[31:0]) | ((wd << (8 * off)) & mask[31:0]);
      lat = (sz == 4) ? 2 : 3;
    end
  endfunction

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_word;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int pulses;
    logic        m_err;
    logic [31:0] m_rd, m_new, w;
    int          m_lat;
    logic [2:0]  f3r;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) tbmem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back('{1'b0, F3_W,   32'h10, 32'h0,        32'h87654321, 32'h87654321, 1'b0, 2, 32'h87654321});
    tbl.push_back('{1'b0, F3_B,   32'h13, 32'h0,        32'h87654321, 32'hFFFFFF87, 1'b0, 2, 32'h87654321});
    tbl.push_back('{1'b0, F3_BU,  32'h13, 32'h0,        32'h87654321, 32'h00000087, 1'b0, 2, 32'h87654321});
    tbl.push_back('{1'b0, F3_H,   32'h12, 32'h0,        32'h87654321, 32'hFFFF8765, 1'b0, 2, 32'h87654321});
    tbl.push_back('{1'b0, F3_HU,  32'h12, 32'h0,        32'h87654321, 32'h00008765, 1'b0, 2, 32'h87654321});
    tbl.push_back('{1'b0, F3_B,   32'h10, 32'h0,        32'h87654321, 32'h00000021, 1'b0, 2, 32'h87654321});
    tbl.push_back('{1'b1, F3_B,   32'h21, 32'h123456AB, 32'h11223344, 32'h0,        1'b0, 3, 32'h1122AB44});
    tbl.push_back('{1'b1, F3_H,   32'h22, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b0, 3, 32'hBEEF3344});
    tbl.push_back('{1'b1, F3_B,   32'h2F, 32'h0000005A, 32'h11223344, 32'h0,        1'b0, 3, 32'h5A223344});
    tbl.push_back('{1'b1, F3_W,   32'h24, 32'hCAFEF00D, 32'h11223344, 32'h0,        1'b0, 2, 32'hCAFEF00D});
    tbl.push_back('{1'b0, F3_W,   32'h06, 32'h0,        32'h87654321, 32'h0,        1'b1, 1, 32'h87654321});
    tbl.push_back('{1'b1, F3_H,   32'h31, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b1, 1, 32'h11223344});
    tbl.push_back('{1'b0, 3'b011, 32'h08, 32'h0,        32'h87654321, 32'h0,        1'b1, 1, 32'h87654321});
    tbl.push_back('{1'b1, 3'b100, 32'h08, 32'h000000FF, 32'h11223344, 32'h0,        1'b1, 1, 32'h11223344});
    tbl.push_back('{1'b0, F3_H,   32'h11, 32'h0,        32'h87654321, 32'h0,        1'b1, 1, 32'h87654321});

    foreach (tbl[i]) begin
      preload(tbl[i].addr[5:2], tbl[i].init);
      run_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
      pulses = (tbl[i].we && !tbl[i].e_err) ? 1 : 0;
      verify($sformatf("vec%0d", i), tbl[i].e_err, tbl[i].e_rd, tbl[i].e_lat, pulses,
             tbl[i].addr & ~32'h3, tbl[i].e_word);
      check($sformatf("vec%0d mem_word", i), tbmem[tbl[i].addr[5:2]], tbl[i].e_word);
    end

    // Reset during the READ of a byte store: no write, no response, clean restart.
    preload(4'd4, 32'h87654321);
    run_access(1'b0, F3_W, 32'h10, 32'h0);
    verify("pre_rst lw", 1'b0, 32'h87654321, 2, 0, 32'h0, 32'h0);
    preload(4'd8, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h21; bus.req_wdata = 32'hAB;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid in_read mem_addr", bus.mem_addr, 32'h20);
    rst = 1'b1;
    #1;
    check("rst_mid req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mid resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mid resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mid mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid mem_addr", bus.mem_addr, 32'd0);
    check("rst_mid mem_wdata", bus.mem_wdata, 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.mem_we || bus.resp_valid) pulses++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.mem_we || bus.resp_valid) pulses++;
    end
    check("rst_mid no_activity", pulses, 0);
    check("rst_mid mem_untouched", tbmem[8], 32'h11223344);
    run_access(1'b0, F3_BU, 32'h21, 32'h0);
    verify("post_rst lbu", 1'b0, 32'h00000033, 2, 0, 32'h0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      preload(4'(i), w);
      refmem[i] = w;
    end
    for (int n = 0; n < 80; n++) begin
      logic        we;
      logic [31:0] addr, wd;
      we = 1'($urandom);
      f3r = 3'($urandom);
      addr = $urandom;
      wd = $urandom;
      model(we, f3r, addr, wd, refmem[addr[5:2]], m_err, m_rd, m_lat, m_new);
      run_access(we, f3r, addr, wd);
      verify($sformatf("rnd%0d we=%0d f3=%0d a=%h", n, we, f3r, addr), m_err, m_rd, m_lat,
             (we && !m_err) ? 1 : 0, addr & ~32'h3, m_new);
      refmem[addr[5:2]] = m_new;
    end
    for (int i = 0; i < 16; i++) check($sformatf("final mem[%0d]", i), tbmem[i], refmem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the CPU execute stage and the word-only data memory, which has a combinational word read and a word write on the clock edge.
- Turns RV32I byte and halfword accesses into word accesses.
- Loads: selects the byte or halfword lane and extends it (sign or zero).
- Stores: word stores write directly; SB/SH do read-modify-write in a small FSM.
- The CPU is held off with a valid/ready handshake.

Parameters:
ADDR_W, 32, address width on the CPU and memory sides
DATA_W, 32, word width; only 32 is supported

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  CPU presents an access
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned address or illegal funct3
mem_addr  out  ADDR_W  word address to the data memory, {addr[31:2],2'b00}
mem_we  out  1  memory write enable
mem_wdata  out  DATA_W  full word to write
mem_rdata  in  DATA_W  combinational memory read data

Behaviour:
- Reset values, and the effect of asserting rst in any state: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_wdata=0; all capture registers cleared. Reset in the middle of an access drops it with no write and no response.
- States: IDLE, READ, WRITE, RESP.
- Accept: a request is taken when req_valid & req_ready in IDLE. At that edge we, funct3, addr and wdata are registered. Request inputs are ignored outside IDLE.
- Error check, at accept:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load 011/110/111, or store with funct3[2]=1.
  - On error: IDLE->RESP, resp_err=1, no memory access. Latency is 1 cycle.
- Load path:
  - IDLE->READ->RESP.
  - In READ: mem_addr is driven. The lane is chosen by addr[1:0] (byte) or addr[1] (halfword). It is extended per funct3[2] (1=zero-extend) and registered.
  - resp_valid rises 2 cycles after accept.
- SW path:
  - IDLE->WRITE->RESP.
  - In WRITE: mem_we=1 and mem_wdata=wdata.
  - Latency is 2 cycles.
- SB/SH path:
  - IDLE->READ->WRITE->RESP.
  - READ registers mem_rdata.
  - WRITE drives the merged word: only the addressed byte or halfword lane is replaced by wdata[7:0] or wdata[15:0]; the other lanes keep the old value.
  - Latency is 3 cycles.
- mem_we is registered state decode: high only in WRITE, exactly one cycle per store.
- mem_addr holds the captured word address in READ and WRITE, and is 0 otherwise.
- RESP: resp_valid=1 for one cycle, then RESP->IDLE. req_ready returns to 1 the cycle after RESP, so the maximum throughput is 1 access per 3 cycles for loads.
- resp_rdata and resp_err hold their last values until the next RESP; they are qualified only by resp_valid.
- The CPU must keep a request stable only while req_valid & !req_ready. A request is never dropped while req_valid is high.

Decomposition:
- Shared package/defines:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding enum (2 bits).
  - The ADDR_SIZE/WORD_LEN macros already used by the memories.
- One natural sub-module, lsu_lane: purely combinational.
  - Load side: extract and extend from (word, addr[1:0], funct3).
  - Store side: merge (old word, new data, addr[1:0], funct3).
  - Both the READ and WRITE datapaths use it. The FSM stays in lsu_subword.

Test Plan:
- LW at 0x0000_0010 with mem word 0x8765_4321 -> resp_valid 2 cycles after accept, resp_rdata=0x8765_4321, resp_err=0, mem_we never high.
- LB at 0x13 and LBU at 0x13, word 0x8765_4321 -> 0xFFFF_FF87 and 0x0000_0087. LH at 0x12 -> 0xFFFF_8765.
- SB 0xAB at 0x21, old word 0x1122_3344 -> one mem_we pulse 2 cycles after accept, mem_addr=0x20, mem_wdata=0x1122_AB44; resp 3 cycles after accept.
- SH 0xBEEF at 0x22 over 0x1122_3344 -> mem_wdata=0xBEEF_3344. SW 0xCAFEF00D at 0x24 -> mem_we 1 cycle after accept, data unchanged.
- LW at 0x0000_0006, and SH at 0x31 -> resp_err=1 one cycle after accept, mem_we stays 0, resp_rdata=0. funct3=011 load -> resp_err=1.
- SB accepted, rst asserted during READ -> all outputs at reset values immediately, no mem_we pulse, no resp_valid; next request is accepted normally.
